// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: transmit FSM encodings, frame geometry, mouse command/response bytes
// and the receive frame check.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQUEST   = 3'd2;
  localparam logic [2:0] ST_TX        = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

  // Frame is {stop, parity, d7..d0, start}; parity is odd over data plus parity bit.
  function automatic logic frame_error(input logic [FRAME_BITS-1:0] f);
    return f[0] | ~f[FRAME_BITS-1] | ~(^f[FRAME_BITS-2:1]);
  endfunction

endpackage

// File: rtl/ps2_debounce.sv
// Two-flop synchroniser plus stability filter for one PS/2 line; the output follows the line
// only after the synchronised level has differed from it for 2^debounce_size consecutive cycles.
module ps2_debounce #(
  parameter int debounce_size = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  logic                     sync1;
  logic                     sync2;
  logic [debounce_size-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      clean <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == clean) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        clean <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_link.sv
// Open-drain PS/2 host transceiver: debounced receive deserialiser with idle timeout, and a
// host-to-device transmit FSM with inhibit, acknowledge check and a watchdog.
module ps2_link
  import ps2_pkg::*;
#(
  parameter int clk_freq      = 56_750_320,
  parameter int debounce_size = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_ena,
  input  logic [8:0] tx_cmd,
  output logic       tx_busy,
  output logic       ack_error,
  output logic [7:0] ps2_code,
  output logic       ps2_code_new,
  output logic       rx_error,
  inout  wire        ps2_data,
  inout  wire        ps2_clk
);

  localparam int INHIBIT_CYCLES = clk_freq / 10_000;
  localparam int IDLE_CYCLES    = clk_freq / 18_000;
  localparam int WD_CYCLES      = clk_freq * 15 / 1000;
  localparam int TMR_W          = $clog2(INHIBIT_CYCLES + 1);
  localparam int IDLE_W         = $clog2(IDLE_CYCLES + 1);
  localparam int WD_W           = $clog2(WD_CYCLES + 1);

  logic                  clk_db;
  logic                  data_db;
  logic                  clk_prev;
  logic                  clk_fall;
  logic [2:0]            st;
  logic [TMR_W-1:0]      timer;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_fire;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [3:0]            rx_cnt;
  logic [FRAME_BITS-2:0] rx_shift;
  logic [FRAME_BITS-1:0] frame_next;
  logic [8:0]            tx_shift;
  logic [3:0]            bit_cnt;
  logic                  clk_low;
  logic                  data_low;

  assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = data_low ? 1'b0 : 1'bz;

  ps2_debounce #(.debounce_size(debounce_size)) u_clk_db (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_clk),
    .clean (clk_db)
  );

  ps2_debounce #(.debounce_size(debounce_size)) u_data_db (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_data),
    .clean (data_db)
  );

  assign clk_fall   = clk_prev & ~clk_db;
  assign frame_next = {data_db, rx_shift};
  assign wd_fire    = (st != ST_IDLE) && (wd_cnt == WD_W'(WD_CYCLES));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_prev <= 1'b1;
      idle_cnt <= '0;
    end else begin
      clk_prev <= clk_db;
      if (!clk_db)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(IDLE_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Receiver only listens while the transmit FSM is idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_cnt       <= '0;
      rx_shift     <= '0;
      ps2_code     <= '0;
      ps2_code_new <= 1'b0;
      rx_error     <= 1'b0;
    end else if (wd_fire) begin
      rx_cnt <= '0;
    end else if (st == ST_IDLE) begin
      if (clk_fall) begin
        rx_shift <= frame_next[FRAME_BITS-1:1];
        if (rx_cnt == '0)
          ps2_code_new <= 1'b0;
        if (rx_cnt == 4'(FRAME_BITS - 1)) begin
          ps2_code     <= frame_next[8:1];
          rx_error     <= frame_error(frame_next);
          ps2_code_new <= 1'b1;
          rx_cnt       <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (idle_cnt == IDLE_W'(IDLE_CYCLES) && rx_cnt != '0) begin
        rx_cnt       <= '0;
        ps2_code_new <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (st == ST_IDLE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      timer     <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
      clk_low   <= 1'b0;
      data_low  <= 1'b0;
      tx_busy   <= 1'b0;
      ack_error <= 1'b0;
    end else if (wd_fire) begin
      clk_low   <= 1'b0;
      data_low  <= 1'b0;
      ack_error <= 1'b1;
      tx_busy   <= 1'b0;
      st        <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE: begin
          if (tx_ena && rx_cnt == '0 && !clk_fall) begin
            tx_shift  <= tx_cmd;
            tx_busy   <= 1'b1;
            ack_error <= 1'b0;
            timer     <= '0;
            clk_low   <= 1'b1;
            st        <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (timer == TMR_W'(INHIBIT_CYCLES - 1)) begin
            data_low <= 1'b1;
            st       <= ST_REQUEST;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_REQUEST: begin
          clk_low <= 1'b0;
          bit_cnt <= '0;
          st      <= ST_TX;
        end
        ST_TX: begin
          // Nine falls shift out D0..D7 and parity; the tenth releases data as the stop bit.
          if (clk_fall) begin
            if (bit_cnt == 4'd9) begin
              data_low <= 1'b0;
              st       <= ST_ACK;
            end else begin
              data_low <= ~tx_shift[0];
              tx_shift <= {1'b0, tx_shift[8:1]};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            ack_error <= data_db;
            st        <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_db && data_db) begin
            tx_busy <= 1'b0;
            st      <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps2_link.md
# ps2_link

Bidirectional PS/2 line transceiver sitting directly upstream of the mouse decoder: it owns the open-drain clock/data pins, debounces them, deserialises device-to-host frames into bytes, and serialises host-to-device command bytes. It presents a level-style receive flag, which the decoder edge-detects, and a level transmit request/busy handshake that the decoder's init sequence drives.

## Interface
- clk_freq, 56_750_320: system clock frequency in Hz; all protocol timers derive from it.
- debounce_size, 8: debounce counter width; a line level is accepted after 2^debounce_size stable cycles.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- tx_ena  in  1  level transmit request; sampled only when idle
- tx_cmd  in  9  {odd parity, data[7:0]}; parity supplied by requester, sent verbatim
- tx_busy  out  1  high from request acceptance until the line returns idle
- ack_error  out  1  last transmit not acknowledged or timed out
- ps2_code  out  8  last received byte
- ps2_code_new  out  1  high when ps2_code holds a completed frame; low while a frame is in progress
- rx_error  out  1  start/stop/parity error on the last received frame
- ps2_data  inout  1  open-drain: drives 0 or Z only
- ps2_clk  inout  1  open-drain: drives 0 or Z only

## Operation
- Input path per line: 2-FF synchroniser, then debouncer; output updates only after the synchronised value is stable for 2^debounce_size cycles.
- Receive (state IDLE/RX): on each debounced ps2_clk falling edge shift debounced data into an 11-bit register (start, D0..D7 LSB first, parity, stop); increment bit count. First edge clears ps2_code_new.
- On the 11th bit: ps2_code <= D7..D0; rx_error <= (start!=0) | (stop!=1) | (even parity over D+P); ps2_code_new <= 1; count <= 0. Erroneous bytes are still presented.
- Idle timeout: debounced clk high for clk_freq/18_000 cycles (~55 us) with count in 1..10 discards the partial frame, count <= 0, ps2_code_new <= 1, outputs unchanged.
- Transmit FSM: IDLE -> INHIBIT -> REQUEST -> TX -> ACK -> WAIT_IDLE -> IDLE.
  - IDLE: tx_ena=1 and rx count=0 -> latch tx_cmd, tx_busy <= 1, clear ack_error, INHIBIT. tx_ena during a partial receive is deferred until the frame ends or times out.
  - INHIBIT: drive clk low for clk_freq/10_000 cycles (~100 us), then REQUEST.
  - REQUEST: drive data low (start bit), release clk, TX.
  - TX: on each clk falling edge present next bit D0..D7, P; after P, release data, ACK.
  - ACK: on next clk falling edge sample data; data=1 -> ack_error <= 1. Go WAIT_IDLE.
  - WAIT_IDLE: wait for debounced clk=1 and data=1, tx_busy <= 0, IDLE.
- Watchdog: any state other than IDLE for more than clk_freq*15/1000 cycles -> release both lines, ack_error <= 1, tx_busy <= 0, IDLE, rx count <= 0.
- Receiver is gated off from INHIBIT through WAIT_IDLE; device clocks during transmit are not taken as receive bits.

## Timing
- Reset values: tx_busy 0, ack_error 0, ps2_code 0x00, ps2_code_new 0, rx_error 0, both pins Z, FSM IDLE, counters 0; synchroniser/debouncer preset high.
- Reset mid-transfer aborts immediately; pins release in the reset cycle.
- Receive latency: ps2_code_new rises 2 + 2^debounce_size + 1 cycles after the raw 11th clk falling edge.
- tx_busy rises the cycle after tx_ena is sampled in IDLE; tx_ena may drop any time once tx_busy is seen.
- Defaults @56.75 MHz: inhibit 5675 cycles, idle timeout 3152, watchdog 851_254 (20-bit counter).

## Structure
- Package ps2_pkg: FSM state enum; FRAME_BITS=11; command/response constants 0xFF reset, 0xF4 enable reporting, 0xFA ack, 0xAA BAT ok, 0x00 mouse ID.
- Sub-module ps2_debounce (sync + stable counter, parameter debounce_size), instantiated once per line.

## Test plan
- Device sends 0xFA, odd parity 1, valid stop -> ps2_code=0xFA, ps2_code_new 0->1, rx_error=0.
- Device sends 0xAA with parity flipped -> ps2_code=0xAA, rx_error=1.
- tx_ena with tx_cmd=0x1FF, model clocks frame, acks -> clk held low >=5675 cycles, bits 1,1,1,1,1,1,1,1,P=1 seen, ack_error=0, tx_busy falls after idle.
- Same transmit, model leaves data high at ack -> ack_error=1, tx_busy falls.
- Device stops after 5 bits -> after ~3152 idle cycles count clears; following full 0x00 frame decodes as 0x00, rx_error=0.
- tx_ena with no device clocking -> watchdog fires at 851_254 cycles: ack_error=1, tx_busy=0, pins Z; reset asserted mid-TX releases pins in the same cycle.
